// File: rtl/socaudio_multi_timer.sv
// N_CH independent down-counting timers behind a 16-bit register port.
// Snapshot registers (addresses 4/5) are only built when MTIMER_SNAPSHOT_EN is defined.
module socaudio_multi_timer #(
    parameter int N_CH         = 2,
    parameter int WIDTH        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [15:0]     writedata,
    output logic [15:0]     readdata,
    output logic            irq,
    output logic [N_CH-1:0] irq_vec
);

    localparam logic [WIDTH-1:0] RST_P = WIDTH'(RESET_PERIOD);

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD_L = 3'd2,
        REG_PERIOD_H = 3'd3,
        REG_SNAP_L   = 3'd4,
        REG_SNAP_H   = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_e;

    logic [N_CH-1:0][WIDTH-1:0] counter_q, counter_d;
    logic [N_CH-1:0][WIDTH-1:0] period_q, period_d;
    logic [N_CH-1:0]            run_q, run_d;
    logic [N_CH-1:0]            to_q, to_d;
    logic [N_CH-1:0]            cont_q, cont_d;
    logic [N_CH-1:0]            ito_q, ito_d;
    logic [N_CH-1:0]            reload_q, reload_d;
`ifdef MTIMER_SNAPSHOT_EN
    logic [N_CH-1:0][WIDTH-1:0] snap_q, snap_d;
`endif
    logic [15:0]                readdata_q, readdata_d;

    logic wr_en;
    reg_e reg_sel;

    assign wr_en   = chipselect & ~write_n;
    assign reg_sel = reg_e'(address[2:0]);

    always_comb begin
        logic        sel;
        logic        expire;
        logic [31:0] p32;
        counter_d = counter_q;
        period_d  = period_q;
        run_d     = run_q;
        to_d      = to_q;
        cont_d    = cont_q;
        ito_d     = ito_q;
        reload_d  = '0;
`ifdef MTIMER_SNAPSHOT_EN
        snap_d    = snap_q;
`endif
        sel    = 1'b0;
        expire = 1'b0;
        p32    = '0;
        for (int c = 0; c < N_CH; c++) begin
            sel    = wr_en && (address[4:3] == 2'(c));
            expire = !reload_q[c] && run_q[c] && (counter_q[c] == '0);
            p32    = 32'(period_q[c]);

            // A pending force-reload takes the period written on the previous cycle.
            if (reload_q[c]) begin
                counter_d[c] = period_q[c];
            end else if (run_q[c]) begin
                if (expire) begin
                    counter_d[c] = period_q[c];
                    to_d[c]      = 1'b1;
                    if (!cont_q[c]) begin
                        run_d[c] = 1'b0;
                    end
                end else begin
                    counter_d[c] = counter_q[c] - WIDTH'(1);
                end
            end

            if (sel) begin
                case (reg_sel)
                    REG_STATUS: to_d[c] = expire;
                    REG_CONTROL: begin
                        cont_d[c] = writedata[1];
                        ito_d[c]  = writedata[0];
                        if (writedata[2]) begin
                            run_d[c] = 1'b1;
                        end else if (writedata[3]) begin
                            run_d[c] = 1'b0;
                        end
                    end
                    REG_PERIOD_L: begin
                        p32[15:0]   = writedata;
                        period_d[c] = WIDTH'(p32);
                        run_d[c]    = 1'b0;
                        reload_d[c] = 1'b1;
                    end
                    REG_PERIOD_H: begin
                        if (WIDTH > 16) begin
                            p32[31:16]  = writedata;
                            period_d[c] = WIDTH'(p32);
                            run_d[c]    = 1'b0;
                            reload_d[c] = 1'b1;
                        end
                    end
`ifdef MTIMER_SNAPSHOT_EN
                    REG_SNAP_L, REG_SNAP_H: snap_d[c] = counter_q[c];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Read mux; unimplemented channels and registers fall through to zero.
    always_comb begin
        logic [31:0] r32;
        readdata_d = '0;
        r32        = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (address[4:3] == 2'(c)) begin
                case (reg_sel)
                    REG_STATUS:   readdata_d = {14'd0, run_q[c], to_q[c]};
                    REG_CONTROL:  readdata_d = {14'd0, cont_q[c], ito_q[c]};
                    REG_PERIOD_L: begin
                        r32        = 32'(period_q[c]);
                        readdata_d = r32[15:0];
                    end
                    REG_PERIOD_H: begin
                        r32        = 32'(period_q[c]);
                        readdata_d = r32[31:16];
                    end
`ifdef MTIMER_SNAPSHOT_EN
                    REG_SNAP_L: begin
                        r32        = 32'(snap_q[c]);
                        readdata_d = r32[15:0];
                    end
                    REG_SNAP_H: begin
                        r32        = 32'(snap_q[c]);
                        readdata_d = r32[31:16];
                    end
`endif
                    default: readdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q  <= {N_CH{RST_P}};
            period_q   <= {N_CH{RST_P}};
            run_q      <= '0;
            to_q       <= '0;
            cont_q     <= '0;
            ito_q      <= '0;
            reload_q   <= '0;
`ifdef MTIMER_SNAPSHOT_EN
            snap_q     <= '0;
`endif
            readdata_q <= '0;
        end else begin
            counter_q  <= counter_d;
            period_q   <= period_d;
            run_q      <= run_d;
            to_q       <= to_d;
            cont_q     <= cont_d;
            ito_q      <= ito_d;
            reload_q   <= reload_d;
`ifdef MTIMER_SNAPSHOT_EN
            snap_q     <= snap_d;
`endif
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_vec  = to_q & ito_q;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_socaudio_multi_timer.sv
// Directed self-checking bench for socaudio_multi_timer (N_CH=2, WIDTH=32, short reset period).
module tb_socaudio_multi_timer;

    localparam int RST_P = 20;
`ifdef MTIMER_SNAPSHOT_EN
    localparam logic [15:0] SNAP_EXP = 16'h1234;
`else
    localparam logic [15:0] SNAP_EXP = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [1:0]  irq_vec;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    socaudio_multi_timer #(
        .N_CH(2),
        .WIDTH(32),
        .RESET_PERIOD(RST_P)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_vec(irq_vec)
    );

    // All tasks start and end on a falling edge; a write lands on the next rising edge.
    task automatic wr(input int ch, input int rg, input int d);
        address    = {2'(ch), 3'(rg)};
        writedata  = 16'(d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input int ch, input int rg, output logic [15:0] d);
        address = {2'(ch), 3'(rg)};
        @(negedge clk);
        d = readdata;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({irq, irq_vec, readdata} !== 19'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {irq, irq_vec, readdata});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 0, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL reset_status: got %h expected 0", d); end
        rd(0, 2, d);
        total++;
        if (d !== 16'(RST_P)) begin bad++; $display("[TB] FAIL reset_period_l: got %h expected %h", d, 16'(RST_P)); end
        rd(1, 3, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL reset_period_h: got %h expected 0", d); end
        rd(1, 1, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL reset_control: got %h expected 0", d); end
    endtask

    task automatic test_periodic();
        logic [15:0] d;
        do_reset();
        wr(0, 2, 9);
        wr(0, 1, 16'h7);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (irq_vec !== ((k == 10) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL periodic_first k=%0d: got %b expected %b", k, irq_vec, (k == 10) ? 2'b01 : 2'b00);
            end
        end
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL periodic_irq: got %b expected 1", irq); end
        wr(0, 0, 0);
        for (int k = 12; k <= 20; k++) begin
            @(negedge clk);
            total++;
            if (irq_vec !== ((k == 20) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL periodic_second k=%0d: got %b expected %b", k, irq_vec, (k == 20) ? 2'b01 : 2'b00);
            end
        end
        rd(1, 0, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL periodic_ch1_idle: got %h expected 0", d); end
        rd(0, 0, d);
        total++;
        if (d !== 16'd3) begin bad++; $display("[TB] FAIL periodic_ch0_status: got %h expected 3", d); end
    endtask

    task automatic test_oneshot();
        logic [15:0] d;
        int seen;
        do_reset();
        wr(0, 2, 3);
        wr(0, 1, 16'h5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (irq_vec !== ((k == 4) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL oneshot_expiry k=%0d: got %b expected %b", k, irq_vec, (k == 4) ? 2'b01 : 2'b00);
            end
        end
        rd(0, 0, d);
        total++;
        if (d !== 16'd1) begin bad++; $display("[TB] FAIL oneshot_status: got %h expected 1", d); end
        wr(0, 0, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (irq) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("[TB] FAIL oneshot_no_retrigger: got %0d irq cycles expected 0", seen); end
    endtask

    task automatic test_status_collision();
        do_reset();
        wr(0, 2, 3);
        wr(0, 1, 16'h7);
        repeat (3) @(negedge clk);
        wr(0, 0, 0);
        total++;
        if (irq_vec !== 2'b01) begin bad++; $display("[TB] FAIL collision_set_wins: got %b expected 01", irq_vec); end
        wr(0, 0, 0);
        total++;
        if ({irq, irq_vec} !== 3'b000) begin bad++; $display("[TB] FAIL collision_clear: got %b expected 000", {irq, irq_vec}); end
    endtask

    task automatic test_period_write_running();
        logic [15:0] d;
        do_reset();
        wr(0, 2, 9);
        wr(0, 1, 16'h7);
        repeat (4) @(negedge clk);
        wr(0, 2, 6);
        rd(0, 0, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL reload_status: got %h expected 0", d); end
        rd(0, 2, d);
        total++;
        if (d !== 16'd6) begin bad++; $display("[TB] FAIL reload_period: got %h expected 6", d); end
        wr(0, 1, 16'h7);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            total++;
            if (irq_vec !== ((k == 7) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL reload_count k=%0d: got %b expected %b", k, irq_vec, (k == 7) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [15:0] d;
        do_reset();
        wr(0, 2, 16'h1240);
        wr(0, 1, 16'h4);
        repeat (12) @(negedge clk);
        wr(0, 4, 0);
        rd(0, 4, d);
        total++;
        if (d !== SNAP_EXP) begin bad++; $display("[TB] FAIL snap_l: got %h expected %h", d, SNAP_EXP); end
        rd(0, 5, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL snap_h: got %h expected 0", d); end
    endtask

    task automatic test_independent();
        do_reset();
        wr(0, 2, 4);
        wr(1, 2, 3);
        wr(0, 1, 16'h7);
        wr(1, 1, 16'h7);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (irq_vec !== ((k == 5) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL indep_expiry k=%0d: got %b expected %b", k, irq_vec, (k == 5) ? 2'b11 : 2'b00);
            end
        end
        wr(0, 0, 0);
        total++;
        if (irq_vec !== 2'b10) begin bad++; $display("[TB] FAIL indep_clear_ch0: got %b expected 10", irq_vec); end
    endtask

    task automatic test_registers();
        logic [15:0] d;
        int seen;
        do_reset();
        wr(0, 1, 16'hF);
        rd(0, 0, d);
        total++;
        if (d !== 16'd2) begin bad++; $display("[TB] FAIL start_stop_status: got %h expected 2", d); end
        rd(0, 1, d);
        total++;
        if (d !== 16'd3) begin bad++; $display("[TB] FAIL control_readback: got %h expected 3", d); end
        wr(0, 1, 16'h8);
        rd(0, 0, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL stop_status: got %h expected 0", d); end
        wr(1, 3, 16'hABCD);
        rd(1, 3, d);
        total++;
        if (d !== 16'hABCD) begin bad++; $display("[TB] FAIL period_h_readback: got %h expected abcd", d); end
        rd(1, 2, d);
        total++;
        if (d !== 16'(RST_P)) begin bad++; $display("[TB] FAIL period_l_kept: got %h expected %h", d, 16'(RST_P)); end
        wr(2, 2, 5);
        wr(2, 1, 16'h7);
        wr(3, 1, 16'h7);
        rd(2, 1, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL oob_control: got %h expected 0", d); end
        rd(2, 2, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL oob_period: got %h expected 0", d); end
        rd(0, 6, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL reserved_read: got %h expected 0", d); end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (irq) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("[TB] FAIL oob_no_irq: got %0d irq cycles expected 0", seen); end
    endtask

    task automatic test_reset_mid_count();
        logic [15:0] d;
        int seen;
        do_reset();
        wr(0, 2, 2);
        wr(0, 1, 16'h7);
        address = '0;
        repeat (4) @(negedge clk);
        total++;
        if ({irq, readdata} !== 17'h10003) begin bad++; $display("[TB] FAIL midreset_pre: got %h expected 10003", {irq, readdata}); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({irq, irq_vec, readdata} !== 19'd0) begin
            bad++;
            $display("[TB] FAIL midreset_async: got %h expected 0", {irq, irq_vec, readdata});
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (irq) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("[TB] FAIL midreset_idle: got %0d irq cycles expected 0", seen); end
        rd(0, 0, d);
        total++;
        if (d !== 16'd0) begin bad++; $display("[TB] FAIL midreset_status: got %h expected 0", d); end
        wr(0, 1, 16'h5);
        for (int k = 1; k <= RST_P + 1; k++) begin
            @(negedge clk);
            total++;
            if (irq_vec !== ((k == RST_P + 1) ? 2'b01 : 2'b00)) begin
                bad++;
                $display("[TB] FAIL midreset_counter k=%0d: got %b expected %b", k, irq_vec, (k == RST_P + 1) ? 2'b01 : 2'b00);
            end
        end
    endtask

    initial begin
        $display("[TB] starting");
        test_reset();
        test_periodic();
        test_oneshot();
        test_status_collision();
        test_period_write_running();
        test_snapshot();
        test_independent();
        test_registers();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/socaudio_multi_timer.md
SOCAUDIO_MULTI_TIMER -- requirements
Module: socaudio_multi_timer

Interface
REQ-001 Parameter N_CH, default 2: number of independent timer channels, legal range 1..4.
REQ-002 Parameter WIDTH, default 32: counter and period width; only 16 and 32 are legal.
REQ-003 Parameter RESET_PERIOD, default 49999: period value loaded into every channel at reset, truncated to WIDTH.
REQ-004 Port clk, input, 1 bit: clock; all logic is sampled on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port address, input, 5 bits: bits [4:3] select the channel and bits [2:0] select the register.
REQ-007 Port chipselect, input, 1 bit: slave select.
REQ-008 Port write_n, input, 1 bit: active-low write strobe; a write occurs on a cycle with chipselect=1 and write_n=0.
REQ-009 Port writedata, input, 16 bits: write data.
REQ-010 Port readdata, output, 16 bits: registered read data.
REQ-011 Port irq, output, 1 bit: OR of all bits of irq_vec.
REQ-012 Port irq_vec, output, N_CH bits: per-channel interrupt, bit c = TO[c] & ITO[c].

Function
REQ-013 Register map per channel: 0 status {RUN,TO} in bits [1:0]; 1 control {STOP,START,CONT,ITO} in bits [3:0]; 2 period_l; 3 period_h; 4 snap_l; 5 snap_h; 6 and 7 reserved, read 0.
REQ-014 Accesses to a channel index >= N_CH shall read 0, and writes to it shall be ignored.
REQ-015 readdata shall update every cycle from the addressed register, giving 1-cycle read latency, independent of chipselect.
REQ-016 Control write: bits [1:0] stored as {CONT,ITO}; bit 2 (START) sets RUN; bit 3 (STOP) clears RUN; START and STOP are not stored and read back as 0.
REQ-017 If START and STOP are written together, START shall win and RUN=1.
REQ-018 Period write (address 2 or 3) shall update the addressed half immediately, clear RUN, and load the counter with the new period on the next cycle (force-reload).
REQ-019 When WIDTH=16, period_h and snap_h shall read 0 and writes to period_h shall be ignored, including its force-reload.
REQ-020 While RUN=1 and counter != 0, the counter shall decrement by 1 each cycle.
REQ-021 While RUN=1 and counter = 0, the counter shall reload with period and TO shall be set; a period P therefore gives a timeout every P+1 cycles, and P=0 times out every cycle.
REQ-022 On expiry with CONT=0, RUN shall clear in the same cycle as the reload, giving one-shot behaviour.
REQ-023 While RUN=0, the counter shall hold its value; a subsequent START resumes from the held value.
REQ-024 A status write (address 0, any data) shall clear TO; if a timeout occurs in the same cycle, the set wins and TO=1.
REQ-025 A write to snap_l or snap_h shall copy the current counter value into the snapshot register (requires MTIMER_SNAPSHOT_EN).
REQ-026 Channels shall be fully independent; simultaneous expiries on several channels each set their own TO.

Reset
REQ-027 On reset_n=0, the following shall apply asynchronously: counter=RESET_PERIOD, period=RESET_PERIOD, RUN=0, TO=0, CONT=0, ITO=0, snapshot=0, readdata=0, irq=0, irq_vec=0.
REQ-028 Reset asserted mid-count shall abort the count with no timeout; after release the timer stays idle until START is written.

Configuration
REQ-029 When macro MTIMER_SNAPSHOT_EN is defined, the snapshot registers and the behaviour of REQ-025 shall be present.
REQ-030 When MTIMER_SNAPSHOT_EN is undefined, no snapshot storage shall exist, addresses 4 and 5 shall read 0, and writes to them shall be ignored.

Verification
REQ-031 Test: N_CH=2, WIDTH=32; write period 9 to ch0, control 0x7 -> TO[0] rises every 10 cycles, irq=1 after the first expiry, ch1 remains idle.
REQ-032 Test: write control 0x5 (one-shot, ITO set) with period 3 -> exactly one TO set, 4 cycles after start, and RUN=0 afterwards.
REQ-033 Test: issue a status write in the same cycle as an expiry -> TO remains 1; a status write on the next cycle -> TO=0 and irq=0.
REQ-034 Test: write period_l while running at count 5 -> RUN=0 and counter equals the new period 1 cycle later, with no TO.
REQ-035 Test: with MTIMER_SNAPSHOT_EN defined, write snap_l at count 0x1234 -> snap_l reads 0x1234 two cycles later; with the macro undefined, the same read returns 0.
REQ-036 Test: assert reset_n low mid-count -> all outputs are 0 immediately, and the counter reads RESET_PERIOD after release.
